// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the shared-adder controller.
package adder_share_ctrl_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = DATA_W + 1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operands latched at grant time; the adder only ever sees these.
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              op;
    } opnd_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              c_out;
        logic              over;
    } result_t;

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester-side bus of the shared-adder controller.
interface adder_share_ctrl_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 16
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] a_in;
    logic [8*NREQ-1:0] b_in;
    logic [NREQ-1:0]   op_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        sum_out;
    logic              c_out_o;
    logic              over_o;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport master (
        output req, a_in, b_in, op_in,
        input  gnt, done, sum_out, c_out_o, over_o, busy, op_count
    );

    modport slave (
        input  req, a_in, b_in, op_in,
        output gnt, done, sum_out, c_out_o, over_o, busy, op_count
    );
endinterface

// File: rtl/adder_share_ctrl_adder.sv
// Eight-bit add/sub datapath: sub is A + ~B + 1, carry and signed overflow from that sum.
module adder_share_ctrl_adder
    import adder_share_ctrl_pkg::*;
(
    input  opnd_t   opnd_i,
    output result_t res_c
);

    logic [DATA_W-1:0] b_eff;
    logic              cin;
    logic [SUM_W-1:0]  full;

    // Two's-complement add of A and (optionally inverted) B.
    always_comb begin
        cin         = (opnd_i.op == OP_SUB);
        b_eff       = cin ? ~opnd_i.b : opnd_i.b;
        full        = SUM_W'(opnd_i.a) + SUM_W'(b_eff) + SUM_W'(cin);
        res_c.sum   = full[DATA_W-1:0];
        res_c.c_out = full[DATA_W];
        res_c.over  = (opnd_i.a[DATA_W-1] == b_eff[DATA_W-1]) &&
                      (full[DATA_W-1] != opnd_i.a[DATA_W-1]);
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one add/sub datapath among NREQ requesters.
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    adder_share_ctrl_if.slave  bus
);

    localparam int unsigned PTR_W = (NREQ > 2) ? 2 : 1;

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("adder_share_ctrl: NREQ must be in 2..4");
    end

    // First requester at or after ptr, wrapping around.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] w;
        logic             found;
        int unsigned      idx;
        w     = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!found && r[idx[PTR_W-1:0]]) begin
                w     = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] w);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        return oh;
    endfunction

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    opnd_t              opnd_q, opnd_d;
    result_t            res_q, res_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic [PTR_W-1:0]   pick_c;
    logic               any_req_c;
    result_t            adder_res_c;

    // Shared datapath fed only from the latched operand register.
    adder_share_ctrl_adder u_adder (
        .opnd_i (opnd_q),
        .res_c  (adder_res_c)
    );

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            win_q      <= '0;
            opnd_q     <= '0;
            res_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            opnd_q     <= opnd_d;
            res_q      <= res_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            op_count_q <= op_count_d;
        end
    end

    // Next-state: DONE re-arbitrates directly to avoid an IDLE bubble.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (any_req_c) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = any_req_c ? S_EXEC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Arbitration, operand latch, result capture and registered outputs.
    always_comb begin
        any_req_c  = |bus.req;
        pick_c     = rr_pick(bus.req, rr_ptr_q);
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        opnd_d     = opnd_q;
        res_d      = res_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        op_count_d = op_count_q;
        busy_d     = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (any_req_c) begin
                    win_d    = pick_c;
                    rr_ptr_d = PTR_W'((32'(pick_c) + 32'd1) % NREQ);
                    opnd_d.a = bus.a_in[DATA_W*pick_c +: DATA_W];
                    opnd_d.b = bus.b_in[DATA_W*pick_c +: DATA_W];
                    opnd_d.op = bus.op_in[pick_c];
                    gnt_d    = onehot(pick_c);
                end else begin
                    gnt_d    = '0;
                end
            end
            S_EXEC: begin
                res_d      = adder_res_c;
                done_d     = onehot(win_q);
                op_count_d = op_count_q + CNT_W'(1);
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.sum_out  = res_q.sum;
    assign bus.c_out_o  = res_q.c_out;
    assign bus.over_o   = res_q.over;
    assign bus.busy     = busy_q;
    assign bus.op_count = op_count_q;

endmodule
